vga_timing_gen: RTL and testbench

- Produces the pixel-scan interface that all sprite and background drawers consume: DrawX, DrawY and blank, plus the monitor hs/vs sync pins.
- Drawers register one ROM read and one RGB output stage, so their RGB appears two cycles after the DrawX/DrawY that addressed it. This block therefore delays hs/vs and a copy of blank by a matching, parameterised number of cycles.
- Sits at the top level, clocked by the 25 MHz vga_clk; its outputs fan out to every drawer and to the VGA pins.

---
 rtl/vga_timing_gen_pkg.sv | 37 +++
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_timing_gen_sync_delay.sv | 35 +++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: shared VGA 640x480@60 timing constants, counter width
// and the packing of the delayed sync bits.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;
  // One extra bit so that constants equal to 1024 still compare correctly.
  typedef logic [CNT_W:0]   cmp_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  // Bits carried through the sync delay line.
  typedef struct packed {
    logic blank;
    logic vs;
    logic hs;
  } sync_bits_t;

  // Idle values: syncs inactive (high), pixel not visible.
  localparam sync_bits_t SYNC_RST = '{blank: 1'b0, vs: 1'b1, hs: 1'b1};

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-scan bundle consumed by drawers and VGA pins.
//   DrawX/DrawY  current scan position
//   blank        visible pixel, aligned with DrawX/DrawY
//   blank_d/hs/vs  delayed to match drawer RGB latency
//   line_start/frame_start  1-cycle pulses; frame_count frame index
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  cnt_t       DrawX;
  cnt_t       DrawY;
  logic       blank;
  logic       blank_d;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// vga_sync_delay: N-stage shift register with a per-bit reset value.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_d         input word
//   o_q         i_d delayed N cycles (combinational pass-through when N=0)
module vga_sync_delay #(
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (N == 0) begin : g_pass
    logic w_unused;
    assign w_unused = clk ^ rst_n;
    assign o_q = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [N];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < N; i++) r_stage[i] <= RST_VAL;
      end else begin
        r_stage[0] <= i_d;
        for (int unsigned i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[N-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA scan counters and sync generation.
//   vga_clk  pixel clock
//   reset_n  asynchronous active-low reset (release synchronised upstream)
//   vga      master side of vga_timing_gen_if (all outputs registered)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cmp_t HA       = cmp_t'(H_ACTIVE);
  localparam cmp_t VA       = cmp_t'(V_ACTIVE);
  localparam cmp_t HS_START = cmp_t'(H_ACTIVE + H_FP);
  localparam cmp_t HS_END   = cmp_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cmp_t VS_START = cmp_t'(V_ACTIVE + V_FP);
  localparam cmp_t VS_END   = cmp_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t       r_hc, r_vc;
  logic       r_blank, r_hs_raw, r_vs_raw, r_ls, r_fs;
  logic [7:0] r_fc;

  cnt_t       w_hc_nxt, w_vc_nxt;
  cmp_t       w_hx, w_vx;
  logic       w_h_wrap, w_blank_nxt, w_hs_nxt, w_vs_nxt, w_ls_nxt, w_fs_nxt;
  sync_bits_t w_raw, w_dly;

  // Status bits are decoded from the next counter values so that, once
  // registered, they line up with the DrawX/DrawY they describe.
  always_comb begin
    w_h_wrap = (r_hc == H_LAST);
    w_hc_nxt = w_h_wrap ? '0 : r_hc + 1'b1;
    w_vc_nxt = r_vc;
    if (w_h_wrap) w_vc_nxt = (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
    w_hx        = {1'b0, w_hc_nxt};
    w_vx        = {1'b0, w_vc_nxt};
    w_blank_nxt = (w_hx < HA) && (w_vx < VA);
    w_hs_nxt    = !((w_hx >= HS_START) && (w_hx < HS_END));
    w_vs_nxt    = !((w_vx >= VS_START) && (w_vx < VS_END));
    w_ls_nxt    = (w_hc_nxt == '0);
    w_fs_nxt    = w_ls_nxt && (w_vc_nxt == '0);
  end

  // Reset parks the counters on the last pixel of a frame so the first
  // edge after release lands on (0,0) and starts frame 0.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hc     <= H_LAST;
      r_vc     <= V_LAST;
      r_blank  <= SYNC_RST.blank;
      r_hs_raw <= SYNC_RST.hs;
      r_vs_raw <= SYNC_RST.vs;
      r_ls     <= 1'b0;
      r_fs     <= 1'b0;
      r_fc     <= '1;
    end else begin
      r_hc     <= w_hc_nxt;
      r_vc     <= w_vc_nxt;
      r_blank  <= w_blank_nxt;
      r_hs_raw <= w_hs_nxt;
      r_vs_raw <= w_vs_nxt;
      r_ls     <= w_ls_nxt;
      r_fs     <= w_fs_nxt;
      if (w_fs_nxt) r_fc <= r_fc + 8'd1;
    end
  end

  assign w_raw = '{blank: r_blank, vs: r_vs_raw, hs: r_hs_raw};

  vga_sync_delay #(
    .N       (SYNC_DELAY),
    .WIDTH   (3),
    .RST_VAL (SYNC_RST)
  ) u_sync_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .i_d   (w_raw),
    .o_q   (w_dly)
  );

  assign vga.DrawX       = r_hc;
  assign vga.DrawY       = r_vc;
  assign vga.blank       = r_blank;
  assign vga.line_start  = r_ls;
  assign vga.frame_start = r_fs;
  assign vga.frame_count = r_fc;
  assign vga.blank_d     = w_dly.blank;
  assign vga.hs          = w_dly.hs;
  assign vga.vs          = w_dly.vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock:
//   A: default 800x525 timing, SYNC_DELAY=2 (table vectors, line checks, async reset)
//   C: default timing, SYNC_DELAY=0 (hs alignment)
//   B: tiny 17x10 timing, SYNC_DELAY=3 (random resets, 256+ frame run, frame_count wrap)
// Every instance is compared each cycle against a model that derives the
// expected outputs from the number of edges since reset release.
module tb_vga_timing_gen;

  typedef struct {
    int x, y, b, bd, hs, vs, ls, fs, fc;
  } exp_t;

  typedef struct {
    int   t;
    exp_t e;
  } vec_t;

  typedef struct {
    int ht, vt, ha, va, hss, hse, vss, vse, d;
  } tm_t;

  localparam tm_t TM_A = '{800, 525, 640, 480, 656, 752, 490, 492, 2};
  localparam tm_t TM_C = '{800, 525, 640, 480, 656, 752, 490, 492, 0};
  localparam tm_t TM_B = '{17, 10, 10, 6, 12, 15, 7, 9, 3};

  logic clk = 1'b0;
  logic rst_ac = 1'b0;
  logic rst_b  = 1'b0;
  bit   mon_en = 1'b0;
  int   tA = 0, tB = 0;
  int   n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if ifA ();
  vga_timing_gen_if ifB ();
  vga_timing_gen_if ifC ();

  vga_timing_gen #(.SYNC_DELAY(2)) u_dut_a (.vga_clk(clk), .reset_n(rst_ac), .vga(ifA));
  vga_timing_gen #(.SYNC_DELAY(0)) u_dut_c (.vga_clk(clk), .reset_n(rst_ac), .vga(ifC));
  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_DELAY(3)
  ) u_dut_b (.vga_clk(clk), .reset_n(rst_b), .vga(ifB));

  // Edges since reset release; 0 while in reset.
  always @(posedge clk or negedge rst_ac) if (!rst_ac) tA <= 0; else tA <= tA + 1;
  always @(posedge clk or negedge rst_b)  if (!rst_b)  tB <= 0; else tB <= tB + 1;

  function automatic exp_t model(tm_t m, int t);
    exp_t e;
    int   td, xd, yd;
    if (t <= 0) begin
      e = '{m.ht - 1, m.vt - 1, 0, 0, 1, 1, 0, 0, 255};
    end else begin
      e.x  = (t - 1) % m.ht;
      e.y  = ((t - 1) / m.ht) % m.vt;
      e.fc = ((t - 1) / (m.ht * m.vt)) % 256;
      e.b  = (e.x < m.ha && e.y < m.va) ? 1 : 0;
      e.ls = (e.x == 0) ? 1 : 0;
      e.fs = (e.x == 0 && e.y == 0) ? 1 : 0;
      td = t - m.d;
      if (td <= 0) begin
        e.bd = 0; e.hs = 1; e.vs = 1;
      end else begin
        xd = (td - 1) % m.ht;
        yd = ((td - 1) / m.ht) % m.vt;
        e.bd = (xd < m.ha && yd < m.va) ? 1 : 0;
        e.hs = (xd >= m.hss && xd < m.hse) ? 0 : 1;
        e.vs = (yd >= m.vss && yd < m.vse) ? 0 : 1;
      end
    end
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tA=%0d tB=%0d)", name, act, exp, tA, tB);
    end
  endtask

  task automatic chk_dut(string tag, exp_t e, int x, int y, int b, int bd,
                         int hs, int vs, int ls, int fs, int fc);
    chk({tag, ".DrawX"}, x, e.x);
    chk({tag, ".DrawY"}, y, e.y);
    chk({tag, ".blank"}, b, e.b);
    chk({tag, ".blank_d"}, bd, e.bd);
    chk({tag, ".hs"}, hs, e.hs);
    chk({tag, ".vs"}, vs, e.vs);
    chk({tag, ".line_start"}, ls, e.ls);
    chk({tag, ".frame_start"}, fs, e.fs);
    chk({tag, ".frame_count"}, fc, e.fc);
  endtask

  task automatic chk_a(string tag, exp_t e);
    chk_dut(tag, e, ifA.DrawX, ifA.DrawY, ifA.blank, ifA.blank_d, ifA.hs, ifA.vs,
            ifA.line_start, ifA.frame_start, ifA.frame_count);
  endtask

  task automatic chk_b(string tag, exp_t e);
    chk_dut(tag, e, ifB.DrawX, ifB.DrawY, ifB.blank, ifB.blank_d, ifB.hs, ifB.vs,
            ifB.line_start, ifB.frame_start, ifB.frame_count);
  endtask

  task automatic chk_c(string tag, exp_t e);
    chk_dut(tag, e, ifC.DrawX, ifC.DrawY, ifC.blank, ifC.blank_d, ifC.hs, ifC.vs,
            ifC.line_start, ifC.frame_start, ifC.frame_count);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk_a("A", model(TM_A, tA));
      chk_c("C", model(TM_C, tA));
      chk_b("B", model(TM_B, tB));
    end
  end

  localparam int NROW = 17;
  vec_t tbl [NROW];

  initial begin
    int ri;
    int hs_low_a, hs_low_c, first_a, first_c;
    int last_fs, vs_low_b, prev_fc;
    bit saw_wrap;

    // t, {DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start, frame_count}
    tbl[0]  = '{0,    '{799, 524, 0, 0, 1, 1, 0, 0, 255}};
    tbl[1]  = '{1,    '{0,   0,   1, 0, 1, 1, 1, 1, 0}};
    tbl[2]  = '{2,    '{1,   0,   1, 0, 1, 1, 0, 0, 0}};
    tbl[3]  = '{3,    '{2,   0,   1, 1, 1, 1, 0, 0, 0}};
    tbl[4]  = '{640,  '{639, 0,   1, 1, 1, 1, 0, 0, 0}};
    tbl[5]  = '{641,  '{640, 0,   0, 1, 1, 1, 0, 0, 0}};
    tbl[6]  = '{642,  '{641, 0,   0, 1, 1, 1, 0, 0, 0}};
    tbl[7]  = '{643,  '{642, 0,   0, 0, 1, 1, 0, 0, 0}};
    tbl[8]  = '{658,  '{657, 0,   0, 0, 1, 1, 0, 0, 0}};
    tbl[9]  = '{659,  '{658, 0,   0, 0, 0, 1, 0, 0, 0}};
    tbl[10] = '{754,  '{753, 0,   0, 0, 0, 1, 0, 0, 0}};
    tbl[11] = '{755,  '{754, 0,   0, 0, 1, 1, 0, 0, 0}};
    tbl[12] = '{800,  '{799, 0,   0, 0, 1, 1, 0, 0, 0}};
    tbl[13] = '{801,  '{0,   1,   1, 0, 1, 1, 1, 0, 0}};
    tbl[14] = '{802,  '{1,   1,   1, 0, 1, 1, 0, 0, 0}};
    tbl[15] = '{803,  '{2,   1,   1, 1, 1, 1, 0, 0, 0}};
    tbl[16] = '{1601, '{0,   2,   1, 0, 1, 1, 1, 0, 0}};

    ri = 0;
    hs_low_a = 0; hs_low_c = 0; first_a = -1; first_c = -1;

    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    while (ri < NROW && tbl[ri].t == tA) begin chk_a("A.tbl", tbl[ri].e); ri++; end
    rst_ac = 1'b1;

    // Lines 0..2 of A/C, up to DrawX=300, DrawY=2.
    while (tA < 1901) begin
      @(negedge clk);
      while (ri < NROW && tbl[ri].t == tA) begin chk_a("A.tbl", tbl[ri].e); ri++; end
      if (tA >= 1 && tA <= 800) begin
        if (ifA.hs == 1'b0) begin hs_low_a++; if (first_a < 0) first_a = int'(ifA.DrawX); end
        if (ifC.hs == 1'b0) begin hs_low_c++; if (first_c < 0) first_c = int'(ifC.DrawX); end
      end
    end
    chk("A.rows_done", ri, NROW);
    chk("A.hs_low_cycles", hs_low_a, 96);
    chk("A.hs_first_x", first_a, 658);
    chk("C.hs_low_cycles", hs_low_c, 96);
    chk("C.hs_first_x", first_c, 656);

    // Asynchronous reset mid-line: outputs must return before the next edge.
    chk("A.mid_x", int'(ifA.DrawX), 300);
    #2 rst_ac = 1'b0;
    #1;
    chk_a("A.async_rst", model(TM_A, 0));
    chk_c("C.async_rst", model(TM_C, 0));
    @(negedge clk);
    rst_ac = 1'b1;
    @(negedge clk);
    chk_a("A.resume", '{0, 0, 1, 0, 1, 1, 1, 1, 0});

    // B: random-length runs interrupted by random asynchronous resets.
    for (int k = 0; k < 5; k++) begin
      rst_b = 1'b1;
      repeat ($urandom_range(1, 600)) @(negedge clk);
      #($urandom_range(1, 4)) rst_b = 1'b0;
      #1;
      chk_b("B.async_rst", model(TM_B, 0));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // B: uninterrupted run past 256 frames.
    last_fs = -1; vs_low_b = 0; prev_fc = -1; saw_wrap = 1'b0;
    rst_b = 1'b1;
    repeat (257 * 170 + 5) begin
      @(negedge clk);
      if (ifB.frame_start) begin
        if (last_fs >= 0) chk("B.fs_period", tB - last_fs, 170);
        last_fs = tB;
      end
      if (tB >= 1 && tB <= 170 * 256 && ifB.vs == 1'b0) vs_low_b++;
      if (prev_fc == 255 && ifB.frame_count == 8'd0) saw_wrap = 1'b1;
      prev_fc = int'(ifB.frame_count);
    end
    chk("B.vs_low_cycles", vs_low_b, 256 * 34);
    chk("B.fc_wrap_seen", int'(saw_wrap), 1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
